// File: rtl/pagerank_stream_tx.sv
// PageRank contribution stream transmitter.
// Walks one source node per cycle and broadcasts rank/outdeg to its edges.
module pagerank_stream_tx #(
  parameter int NODES_IN_GRAPH = 32
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [63:0]                         init_rank,
  input  logic [NODES_IN_GRAPH-1:0]
               [NODES_IN_GRAPH-1:0]           adjacency,
  input  logic [NODES_IN_GRAPH-1:0][63:0]     pagerank_in,
  input  logic                                next_iteration,
  input  logic                                pagerank_complete,
  output logic [NODES_IN_GRAPH-1:0][63:0]     pagerank_serial_stream,
  output logic                                stream_start,
  output logic                                stream_done,
  output logic                                busy,
  output logic [31:0]                         streams_sent
);

  localparam int N  = NODES_IN_GRAPH;
  localparam int DW = $clog2(N + 1);
  localparam int JW = $clog2(N);
  localparam logic [JW-1:0] LAST = JW'(N - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, STREAM, DONE, WAIT_NEXT
  } state_t;

  state_t                state, state_d;
  logic [JW-1:0]         j, j_d;
  logic [N-1:0][63:0]    rank;
  logic [JW-1:0]         src;
  logic [DW-1:0]         outdeg;
  logic [63:0]           q;
  logic [N-1:0][63:0]    lane;
  logic [N-1:0][63:0]    lanes_d;
  logic                  start_d;
  logic                  done_d;
  logic                  inc;
  logic                  load_init;
  logic                  load_next;

  // Outputs are registered, so the datapath looks one source ahead.
  assign src = (state == LOAD) ? '0 : j + JW'(1);

  always_comb begin
    outdeg = '0;
    for (int i = 0; i < N; i++)
      outdeg = outdeg + DW'(adjacency[src][i]);
  end

  always_comb begin
    q = '0;
    if (outdeg != '0)
      q = rank[src] / {{(64-DW){1'b0}}, outdeg};
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      lane[i] = adjacency[src][i] ? q : 64'd0;
  end

  always_comb begin
    state_d   = state;
    j_d       = j;
    lanes_d   = '0;
    start_d   = 1'b0;
    done_d    = 1'b0;
    inc       = 1'b0;
    load_init = 1'b0;
    load_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load_init = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        j_d     = '0;
        lanes_d = lane;
        start_d = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (j == LAST) begin
          done_d  = 1'b1;
          inc     = 1'b1;
          state_d = DONE;
        end else begin
          j_d     = j + JW'(1);
          lanes_d = lane;
        end
      end
      DONE: state_d = WAIT_NEXT;
      WAIT_NEXT: begin
        if (pagerank_complete) begin
          state_d = IDLE;
        end else if (next_iteration) begin
          load_next = 1'b1;
          state_d   = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      j     <= '0;
    end else begin
      state <= state_d;
      j     <= j_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rank <= '0;
    end else if (load_init) begin
      rank <= {N{init_rank}};
    end else if (load_next) begin
      rank <= pagerank_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pagerank_serial_stream <= '0;
      stream_start           <= 1'b0;
      stream_done            <= 1'b0;
      busy                   <= 1'b0;
      streams_sent           <= '0;
    end else begin
      pagerank_serial_stream <= lanes_d;
      stream_start           <= start_d;
      stream_done            <= done_d;
      busy                   <= (state_d != IDLE);
      if (load_init)
        streams_sent <= '0;
      else if (inc)
        streams_sent <= streams_sent + 32'd1;
    end
  end

endmodule

// File: doc/pagerank_stream_tx.md
# pagerank_stream_tx

Transmitter for the per-iteration PageRank contribution stream consumed by `pagerank_comp`. It holds a snapshot of the current rank vector and walks the graph one source node per cycle. For each source it broadcasts `rank[j] / outdeg(j)` to every destination that source points to. It brackets the walk with `stream_start` and `stream_done`, then re-arms when `nextIteration` arrives from the receiver.

## Interface
- `NODES_IN_GRAPH`, default 32: number of nodes; sets the stream width, the adjacency size and the source counter range. Legal range is 2..64.
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begins a new PageRank run; sampled only in IDLE.
- `init_rank`  in  64: rank loaded for every node on `start`; unsigned fixed-point.
- `adjacency`  in  [NODES_IN_GRAPH] x NODES_IN_GRAPH: `adjacency[j][i]=1` means edge j->i. It must be held stable while `busy`=1.
- `pagerank_in`  in  64 x [NODES_IN_GRAPH]: receiver's `pagerank_final`; sampled on the accepted `next_iteration`.
- `next_iteration`  in  1: one-cycle pulse from the receiver requesting the next stream.
- `pagerank_complete`  in  1: receiver convergence flag.
- `pagerank_serial_stream`  out  64 x [NODES_IN_GRAPH]: per-destination contribution of the current source.
- `stream_start`  out  1: high during the first data cycle (source 0).
- `stream_done`  out  1: one-cycle pulse after the last data cycle; carries no data.
- `busy`  out  1: high in every state except IDLE.
- `streams_sent`  out  32: number of completed streams in the current run.

## Operation
- States are IDLE, LOAD, STREAM, DONE, WAIT_NEXT.
- **IDLE**
  - On `start`=1: every `rank[k]` <= `init_rank`, `streams_sent` <= 0, go to LOAD.
- **LOAD**
  - Lasts one cycle. Source index j <= 0. Go to STREAM.
- **STREAM**
  - Lasts exactly NODES_IN_GRAPH cycles, j = 0..NODES_IN_GRAPH-1.
  - In the cycle with index j: `outdeg` = popcount(`adjacency[j]`), `q` = `rank[j] / outdeg` (unsigned, truncating).
  - `pagerank_serial_stream[i]` = `adjacency[j][i] ? q : 0`.
  - `stream_start` = (j == 0).
  - When j == NODES_IN_GRAPH-1, go to DONE.
- **Dangling source** (`outdeg`=0): `q`=0, so all lanes are 0. No divide is performed and no X may propagate.
- **Self-loop** (`adjacency[j][j]`): counted in `outdeg` and streamed like any other edge.
- **DONE**
  - `stream_done`=1, all stream lanes 0.
  - `streams_sent` increments (wraps at 2^32).
  - Go to WAIT_NEXT.
- **WAIT_NEXT**, evaluated in this priority order:
  - `pagerank_complete`=1: go to IDLE. This wins even if `next_iteration` is high in the same cycle.
  - else `next_iteration`=1: `rank[k]` <= `pagerank_in[k]` for all k, go to LOAD.
- Ignored inputs:
  - `start` outside IDLE.
  - `next_iteration` outside WAIT_NEXT.
  - `pagerank_in` except on the accepted `next_iteration` edge.
- Width rules:
  - `q` is 64 bits; `outdeg` is clog2(NODES_IN_GRAPH+1) bits.
  - Arithmetic is unsigned integer division of the raw 64-bit rank value.

## Timing
- Reset, applied asynchronously at any time including mid-stream:
  - State returns to IDLE.
  - All stream lanes = 0; `stream_start`, `stream_done`, `busy` = 0; `streams_sent` = 0; `rank[]` = 0.
  - No partial stream resumes after reset.
- All outputs are registered.
- Outside STREAM, stream lanes are 0 and `stream_start` is 0.
- Start latency: with `start` sampled at edge E, LOAD is the cycle after E and `stream_start`=1 in the cycle after LOAD (2 cycles after E).
- Stream length: `stream_start` to `stream_done` is exactly NODES_IN_GRAPH cycles.
- Iteration latency: with `next_iteration` sampled at edge E, LOAD is the cycle after E and `stream_start` follows 2 cycles after E.
- Receiver compatibility: `pagerank_comp` accumulates in the `stream_start` cycle and every following cycle until, but excluding, the `stream_done` cycle. Zero lanes in DONE therefore guarantee no spurious accumulation.
- The receiver's `next_iteration` pulse lands while this block is in WAIT_NEXT, never during STREAM.

## Test plan
- Common setup: NODES_IN_GRAPH=4, `init_rank`=1000, adjacency rows 0:0110, 1:0100, 2:0001, 3:0000 (bit i = destination i).
  - Pulse `start`. Lanes in the 4 data cycles are [0,500,500,0], [0,0,1000,0], [1000,0,0,0], [0,0,0,0]; then `stream_done`=1 with lanes 0.
  - A reference accumulator sums [1000,500,1500,0].
- Truncation and dangling source:
  - Row 0 = 1110 and `rank[0]`=1000 gives q=333 on lanes 1..3.
  - Source 3 with row 0000 gives all-zero lanes and no X.
- Iteration handoff:
  - In WAIT_NEXT, drive `pagerank_in`={10,20,30,40} and pulse `next_iteration`.
  - `stream_start` follows 2 cycles later; source 1 lane 2 = 20.
  - `streams_sent` goes 1 -> 2.
- Termination:
  - Assert `pagerank_complete` and `next_iteration` in the same WAIT_NEXT cycle.
  - Block returns to IDLE, `busy`=0, no further `stream_start`.
- Illegal/ignored inputs:
  - `start` and `next_iteration` pulsed mid-STREAM cause no change to sequence or data.
  - `pagerank_in` changed mid-STREAM does not alter the lanes.
- Reset mid-stream:
  - Drop `reset_n` during source 2. All outputs go 0 immediately, `busy`=0.
  - After release, a new `start` reproduces the common-setup stream exactly.
